branch_unit_ras: RTL

//  Registered branch-resolution unit for the KGP_RISC core. Decodes jump, conditional

---
 rtl/kgp_branch_pkg.sv | 34 +++
 rtl/ras_stack.sv | 61 ++++++
 rtl/branch_unit_ras.sv | 93 +++++++++
 3 files changed

// File: rtl/kgp_branch_pkg.sv
// Opcode and function-code encodings for KGP_RISC branches, shared with the decoder.
package kgp_branch_pkg;
  localparam logic [2:0] OPC_JUMP = 3'b011;
  localparam logic [2:0] OPC_BR   = 3'b100;

  localparam logic [3:0] FC_B    = 4'd0;
  localparam logic [3:0] FC_BZ   = 4'd1;
  localparam logic [3:0] FC_BNZ  = 4'd2;
  localparam logic [3:0] FC_BCY  = 4'd3;
  localparam logic [3:0] FC_BNCY = 4'd4;
  localparam logic [3:0] FC_BS   = 4'd5;
  localparam logic [3:0] FC_BNS  = 4'd6;
  localparam logic [3:0] FC_BV   = 4'd7;
  localparam logic [3:0] FC_BNV  = 4'd8;
  localparam logic [3:0] FC_CALL = 4'd9;
  localparam logic [3:0] FC_RET  = 4'd10;

  // Flag condition for the plain conditional branches; call/ret/reserved return 0.
  function automatic logic br_cond(input logic [3:0] fc, input logic c, input logic z,
                                   input logic o, input logic s);
    case (fc)
      FC_B:    br_cond = 1'b1;
      FC_BZ:   br_cond = z;
      FC_BNZ:  br_cond = ~z;
      FC_BCY:  br_cond = c;
      FC_BNCY: br_cond = ~c;
      FC_BS:   br_cond = s;
      FC_BNS:  br_cond = ~s;
      FC_BV:   br_cond = o;
      FC_BNV:  br_cond = ~o;
      default: br_cond = 1'b0;
    endcase
  endfunction
endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int PC_W      = 8,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  logic                         i_flush,
  input  logic [PC_W-1:0]              i_data,
  output logic [PC_W-1:0]              o_top,
  output logic [$clog2(RAS_DEPTH):0]   o_cnt,
  output logic                         o_ovf,
  output logic                         o_unf
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            r_ovf, r_unf;
  logic [PW-1:0]   w_top_idx;
  logic            w_full, w_empty;

  // r_ptr is the next free slot; once full it also points at the oldest entry.
  assign w_top_idx = r_ptr - 1'b1;
  assign w_full    = (r_cnt == CW'(RAS_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign o_top     = w_empty ? '0 : r_mem[w_top_idx];
  assign o_cnt     = r_cnt;
  assign o_ovf     = r_ovf;
  assign o_unf     = r_unf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_mem[i] <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (i_flush) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= i_push & w_full;
      r_unf <= i_pop & w_empty;
      if (i_push) begin
        r_mem[r_ptr] <= i_data;
        r_ptr        <= r_ptr + 1'b1;
        if (!w_full) r_cnt <= r_cnt + 1'b1;
      end else if (i_pop && !w_empty) begin
        r_ptr <= w_top_idx;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/branch_unit_ras.sv
// Registered branch resolution with a return-address stack for nested call/return.
module branch_unit_ras
  import kgp_branch_pkg::*;
#(
  parameter int PC_W      = 8,
  parameter int LBL_W     = 25,
  parameter int RAS_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic                        flush_i,
  input  logic [2:0]                  opcode_i,
  input  logic [3:0]                  fcode_i,
  input  logic [LBL_W-1:0]            lbl_i,
  input  logic                        c_i,
  input  logic                        z_i,
  input  logic                        o_i,
  input  logic                        s_i,
  input  logic [PC_W-1:0]             pc_i,
  output logic [PC_W-1:0]             target_o,
  output logic                        pc_src_o,
  output logic [PC_W-1:0]             ra_o,
  output logic [$clog2(RAS_DEPTH):0]  ras_cnt_o,
  output logic                        ras_ovf_o,
  output logic                        ras_unf_o
);
  logic [PC_W-1:0]            w_top;
  logic [$clog2(RAS_DEPTH):0] w_cnt;
  logic                       w_taken, w_push, w_pop;
  logic [PC_W-1:0]            w_tgt;
  logic [PC_W-1:0]            r_target;
  logic                       r_pc_src;

  generate
    if (LBL_W > PC_W) begin : g_lbl_hi
      logic w_unused_lbl;
      assign w_unused_lbl = ^lbl_i[LBL_W-1:PC_W];
    end
  endgenerate

  always_comb begin
    w_taken = 1'b0;
    w_push  = 1'b0;
    w_pop   = 1'b0;
    w_tgt   = lbl_i[PC_W-1:0];
    if (valid_i && !flush_i) begin
      if (opcode_i == OPC_JUMP) begin
        w_taken = 1'b1;
      end else if (opcode_i == OPC_BR) begin
        if (fcode_i == FC_CALL) begin
          w_taken = 1'b1;
          w_push  = 1'b1;
        end else if (fcode_i == FC_RET) begin
          // Pop on empty is reported as underflow by the stack, never taken.
          w_pop   = 1'b1;
          w_taken = (w_cnt != '0);
          w_tgt   = w_top;
        end else begin
          w_taken = br_cond(fcode_i, c_i, z_i, o_i, s_i);
        end
      end
    end
  end

  ras_stack #(.PC_W(PC_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush_i),
    .i_data  (pc_i),
    .o_top   (w_top),
    .o_cnt   (w_cnt),
    .o_ovf   (ras_ovf_o),
    .o_unf   (ras_unf_o)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= '0;
      r_pc_src <= 1'b0;
    end else begin
      r_pc_src <= w_taken;
      r_target <= w_taken ? w_tgt : '0;
    end
  end

  assign target_o  = r_target;
  assign pc_src_o  = r_pc_src;
  assign ra_o      = w_top;
  assign ras_cnt_o = w_cnt;
endmodule
